// File: rtl/floo_pkg.sv
// floo_pkg: shared mode and state encodings for the ID-to-address translator
package floo_pkg;
  typedef enum logic [1:0] {
    TableSearch = 2'd0,
    XYCompose   = 2'd1,
    IdCompose   = 2'd2
  } route_mode_e;
  typedef enum logic [1:0] {
    Idle   = 2'd0,
    Search = 2'd1,
    Resp   = 2'd2
  } id_state_e;
endpackage

// File: rtl/floo_id_rule_match.sv
// floo_id_rule_match: compares one chunk of rule IDs and picks the lowest-index hit
module floo_id_rule_match #(
  parameter int unsigned N = 2,
  parameter int unsigned IdWidth = 8,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [IdWidth-1:0]   id_i,
  input  logic [N*IdWidth-1:0] rule_id_i,
  output logic                 hit_o,
  output logic [IdxW-1:0]      idx_o
);
  // scan from the top down so the lowest matching index is the one left standing
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rule_id_i[i*IdWidth +: IdWidth] == id_i) begin
        hit_o = 1'b1;
        idx_o = IdxW'(i);
      end
    end
  end
endmodule

// File: rtl/floo_id_to_addr.sv
// floo_id_to_addr: translates a destination ID into an address region by table search or field composition
module floo_id_to_addr
  import floo_pkg::*;
#(
  parameter int unsigned Mode          = 0,
  parameter int unsigned NumRules      = 8,
  parameter int unsigned RulesPerCycle = 2,
  parameter int unsigned IdWidth       = 8,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned XWidth        = 4,
  parameter int unsigned YWidth        = 4,
  parameter int unsigned XYAddrOffsetX = 16,
  parameter int unsigned XYAddrOffsetY = 20,
  parameter int unsigned IdAddrOffset  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [IdWidth-1:0]            req_id_i,
  input  logic [NumRules*IdWidth-1:0]   rule_id_i,
  input  logic [NumRules*AddrWidth-1:0] rule_start_i,
  input  logic [NumRules*AddrWidth-1:0] rule_end_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [AddrWidth-1:0]          rsp_addr_o,
  output logic [AddrWidth-1:0]          rsp_end_o,
  output logic                          rsp_err_o
);
  localparam int unsigned NumChunks = NumRules / RulesPerCycle;
  localparam int unsigned CntW  = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int unsigned IdxW  = (RulesPerCycle > 1) ? $clog2(RulesPerCycle) : 1;
  localparam int unsigned RuleW = (NumRules > 1) ? $clog2(NumRules) : 1;
  localparam bit IsSearch = (Mode == int'(TableSearch));
  localparam bit IsXY     = (Mode == int'(XYCompose));

  if (Mode > int'(IdCompose)) begin : g_bad_mode
    $fatal(1, "floo_id_to_addr: unsupported Mode %0d", Mode);
  end
  if (NumRules % RulesPerCycle != 0) begin : g_bad_rpc
    $fatal(1, "floo_id_to_addr: RulesPerCycle must divide NumRules");
  end

  id_state_e state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdWidth-1:0]   id_q, id_d;
  logic [AddrWidth-1:0] addr_q, addr_d, end_q, end_d;
  logic                 err_q, err_d;
  logic                 accept, seek, hit, last;
  logic [CntW-1:0]      chunk;
  logic [IdWidth-1:0]   cmp_id;
  logic [IdxW-1:0]      hit_idx;
  logic [RuleW-1:0]     rule_idx;
  logic [AddrWidth-1:0] comp_addr;

  // the accept cycle already checks chunk 0 against the live ID, so a hit in chunk k responds k+1 cycles later
  assign accept   = (state_q == Idle) && req_valid_i;
  assign seek     = (accept && IsSearch) || (state_q == Search);
  assign chunk    = (state_q == Idle) ? '0 : cnt_q;
  assign cmp_id   = (state_q == Idle) ? req_id_i : id_q;
  assign last     = (chunk == CntW'(NumChunks - 1));
  assign rule_idx = RuleW'(chunk * RulesPerCycle + hit_idx);
  assign comp_addr = IsXY ? ((AddrWidth'(req_id_i[XWidth-1:0]) << XYAddrOffsetX) |
                             (AddrWidth'(req_id_i[XWidth +: YWidth]) << XYAddrOffsetY))
                          : (AddrWidth'(req_id_i) << IdAddrOffset);

  floo_id_rule_match #(
    .N       (RulesPerCycle),
    .IdWidth (IdWidth),
    .IdxW    (IdxW)
  ) u_match (
    .id_i      (cmp_id),
    .rule_id_i (rule_id_i[chunk*RulesPerCycle*IdWidth +: RulesPerCycle*IdWidth]),
    .hit_o     (hit),
    .idx_o     (hit_idx)
  );

  // next state: capture on accept, walk chunks until a hit or the last chunk, hold the response until taken
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    addr_d  = addr_q;
    end_d   = end_q;
    err_d   = err_q;
    if (accept) begin
      id_d  = req_id_i;
      cnt_d = '0;
      if (!IsSearch) begin
        state_d = Resp;
        addr_d  = comp_addr;
        end_d   = '0;
        err_d   = 1'b0;
      end
    end
    if (seek) begin
      state_d = (hit || last) ? Resp : Search;
      cnt_d   = chunk + 1'b1;
      addr_d  = hit ? rule_start_i[rule_idx*AddrWidth +: AddrWidth] : '0;
      end_d   = hit ? rule_end_i[rule_idx*AddrWidth +: AddrWidth] : '0;
      err_d   = !hit;
    end
    if (state_q == Resp && rsp_ready_i) state_d = Idle;
  end

  // state and response registers; reset aborts any search or pending response at once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= Idle;
      cnt_q   <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      end_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = (state_q == Idle);
  assign rsp_valid_o = (state_q == Resp);
  assign rsp_addr_o  = addr_q;
  assign rsp_end_o   = end_q;
  assign rsp_err_o   = err_q;

  rsp_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_valid_o && !rsp_ready_i |=> rsp_valid_o && $stable(rsp_addr_o) && $stable(rsp_end_o) && $stable(rsp_err_o));

  if (IsSearch) begin : g_miss_warn
    miss_w: assert property (@(posedge clk_i) disable iff (rst_i) $rose(rsp_valid_o) |-> !rsp_err_o)
      else $warning("floo_id_to_addr: id %0h matched no rule", id_q);
  end
endmodule
